// File: rtl/gmii_rx_deframer_if.sv
// GMII receive inputs and the deframed byte stream produced by gmii_rx_deframer.
// master drives GMII and sinks the stream; slave is the deframer itself.
interface gmii_rx_deframer_if;
   logic [7:0] gmii_rxd_i;
   logic       gmii_rx_dv_i;
   logic       gmii_rx_er_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       sof_o;
   logic       eof_o;
   logic       err_o;
   logic       crc_ok_o;

   modport master (
      output gmii_rxd_i, gmii_rx_dv_i, gmii_rx_er_i,
      input  data_o, valid_o, sof_o, eof_o, err_o, crc_ok_o
   );

   modport slave (
      input  gmii_rxd_i, gmii_rx_dv_i, gmii_rx_er_i,
      output data_o, valid_o, sof_o, eof_o, err_o, crc_ok_o
   );
endinterface

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, checks CRC-32 and length, and emits
// a byte stream with sof/eof/err markers through a one-byte hold buffer.
module gmii_rx_deframer #(
   parameter int unsigned MIN_PREAMBLE  = 1,
   parameter int unsigned MAX_FRAME_LEN = 1522,
   parameter int unsigned LEN_W         = 11
) (
   input logic               clk,
   input logic               rst,
   gmii_rx_deframer_if.slave bus
);

   localparam int unsigned      PRE_W       = $clog2(MIN_PREAMBLE + 1) + 1;
   localparam logic [PRE_W-1:0] PRE_MIN     = PRE_W'(MIN_PREAMBLE);
   localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(MAX_FRAME_LEN);
   localparam logic [LEN_W-1:0] LEN_MIN     = LEN_W'(5);
   localparam logic [7:0]       PRE_BYTE    = 8'h55;
   localparam logic [7:0]       SFD_BYTE    = 8'hD5;
   localparam logic [31:0]      CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0]      CRC_POLY_R  = 32'hEDB8_8320;
   localparam logic [31:0]      RESIDUE     = 32'hDEBB_20E3;
   localparam logic [31:0]      RESIDUE_INV = 32'h2144_DF1C;

   typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'd0, b};
      for (int unsigned i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
      end
      return c;
   endfunction

   logic [7:0]       rxd_q;
   logic             dv_q;
   logic             er_q;

   state_t           state_q,    state_d;
   logic [PRE_W-1:0] pre_q,      pre_d;
   logic [7:0]       hold_q,     hold_d;
   logic             hold_vld_q, hold_vld_d;
   logic             sof_done_q, sof_done_d;
   logic [LEN_W-1:0] cnt_q,      cnt_d;
   logic [31:0]      crc_q,      crc_d;
   logic             er_seen_q,  er_seen_d;

   logic [7:0]       data_q,     data_d;
   logic             valid_q,    valid_d;
   logic             sof_q,      sof_d;
   logic             eof_q,      eof_d;
   logic             err_q,      err_d;
   logic             crc_ok_q,   crc_ok_d;

   logic             crc_match;

   assign crc_match = (crc_q == RESIDUE) || (crc_q == RESIDUE_INV);

   always_comb begin
      state_d    = state_q;
      pre_d      = pre_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      sof_done_d = sof_done_q;
      cnt_d      = cnt_q;
      crc_d      = crc_q;
      er_seen_d  = er_seen_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      sof_d      = 1'b0;
      eof_d      = 1'b0;
      err_d      = 1'b0;
      crc_ok_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (dv_q) begin
               if (rxd_q == PRE_BYTE) begin
                  state_d = PREAMBLE;
                  pre_d   = PRE_W'(1);
               end else begin
                  state_d = DROP;
               end
            end
         end

         PREAMBLE: begin
            if (!dv_q) begin
               state_d = IDLE;
            end else if (rxd_q == PRE_BYTE) begin
               if (pre_q != '1) pre_d = pre_q + 1'b1;
            end else if (rxd_q == SFD_BYTE && pre_q >= PRE_MIN) begin
               state_d    = PAYLOAD;
               crc_d      = CRC_INIT;
               cnt_d      = '0;
               er_seen_d  = 1'b0;
               hold_vld_d = 1'b0;
               sof_done_d = 1'b0;
            end else begin
               state_d = DROP;
            end
         end

         PAYLOAD: begin
            if (dv_q && cnt_q == LEN_MAX) begin
               // Overlong: the held byte closes the frame as an error; the rest of the burst is discarded.
               valid_d    = hold_vld_q;
               data_d     = hold_q;
               sof_d      = hold_vld_q && !sof_done_q;
               eof_d      = hold_vld_q;
               err_d      = hold_vld_q;
               hold_vld_d = 1'b0;
               state_d    = DROP;
            end else if (dv_q) begin
               hold_d     = rxd_q;
               hold_vld_d = 1'b1;
               cnt_d      = cnt_q + 1'b1;
               crc_d      = crc32_byte(crc_q, rxd_q);
               if (er_q) er_seen_d = 1'b1;
               if (hold_vld_q) begin
                  valid_d    = 1'b1;
                  data_d     = hold_q;
                  sof_d      = !sof_done_q;
                  sof_done_d = 1'b1;
               end
            end else begin
               state_d    = IDLE;
               hold_vld_d = 1'b0;
               if (hold_vld_q) begin
                  valid_d    = 1'b1;
                  data_d     = hold_q;
                  sof_d      = !sof_done_q;
                  eof_d      = 1'b1;
                  err_d      = er_seen_q || (cnt_q < LEN_MIN);
                  crc_ok_d   = crc_match;
                  sof_done_d = 1'b1;
               end
            end
         end

         DROP: begin
            if (!dv_q) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_q      <= '0;
         dv_q       <= 1'b0;
         er_q       <= 1'b0;
         state_q    <= IDLE;
         pre_q      <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         sof_done_q <= 1'b0;
         cnt_q      <= '0;
         crc_q      <= '0;
         er_seen_q  <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
         err_q      <= 1'b0;
         crc_ok_q   <= 1'b0;
      end else begin
         rxd_q      <= bus.gmii_rxd_i;
         dv_q       <= bus.gmii_rx_dv_i;
         er_q       <= bus.gmii_rx_er_i;
         state_q    <= state_d;
         pre_q      <= pre_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         sof_done_q <= sof_done_d;
         cnt_q      <= cnt_d;
         crc_q      <= crc_d;
         er_seen_q  <= er_seen_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         sof_q      <= sof_d;
         eof_q      <= eof_d;
         err_q      <= err_d;
         crc_ok_q   <= crc_ok_d;
      end
   end

   assign bus.data_o   = data_q;
   assign bus.valid_o  = valid_q;
   assign bus.sof_o    = sof_q;
   assign bus.eof_o    = eof_q;
   assign bus.err_o    = err_q;
   assign bus.crc_ok_o = crc_ok_q;

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Bench for gmii_rx_deframer: two instances (default and MAX_FRAME_LEN=8) share one
// GMII stimulus; a frame-level model predicts each output stream.
module tb_gmii_rx_deframer;

   logic clk = 1'b0;
   logic rst;
   always #4 clk = ~clk;

   gmii_rx_deframer_if b0 ();
   gmii_rx_deframer_if b1 ();

   assign b1.gmii_rxd_i   = b0.gmii_rxd_i;
   assign b1.gmii_rx_dv_i = b0.gmii_rx_dv_i;
   assign b1.gmii_rx_er_i = b0.gmii_rx_er_i;

   gmii_rx_deframer #(.MIN_PREAMBLE(1), .MAX_FRAME_LEN(1522), .LEN_W(11)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (b0.slave)
   );

   gmii_rx_deframer #(.MIN_PREAMBLE(1), .MAX_FRAME_LEN(8), .LEN_W(4)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       sof;
      logic       eof;
      logic       err;
      logic       ok;
   } exp_t;

   exp_t       q0[$];
   exp_t       q1[$];
   int         tests = 0;
   int         fails = 0;
   bit         skip = 1'b0;
   int         eof_seen = 0;
   logic [7:0] fb[$];
   bit         fe[$];
   logic [7:0] dat[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // FCS value (as transmitted, LSB byte first) of fb[from +: cnt], bit-serial form
   function automatic logic [31:0] fcs_of(input int from, input int cnt);
      logic [31:0] c;
      bit          x;
      c = '1;
      for (int i = from; i < from + cnt; i++) begin
         for (int k = 0; k < 8; k++) begin
            x = c[0] ^ fb[i][k];
            c = {1'b0, c[31:1]} ^ (x ? 32'hEDB8_8320 : 32'h0);
         end
      end
      return ~c;
   endfunction

   // Expected stream for the burst in fb/fe as seen by an instance with limit maxl
   function automatic void model(input int which);
      int   maxl;
      int   i, start, n, m;
      bit   anyer, ok;
      exp_t e;
      maxl  = (which != 0) ? 8 : 1522;
      i     = 0;
      anyer = 1'b0;
      while (i < fb.size() && fb[i] == 8'h55) i++;
      if (i < 1 || i >= fb.size() || fb[i] != 8'hD5) return;
      start = i + 1;
      n     = fb.size() - start;
      if (n == 0) return;
      m = (n > maxl) ? maxl : n;
      for (int j = 0; j < m; j++) if (fe[start + j]) anyer = 1'b1;
      ok = (n >= 4) && ({fb[start+n-1], fb[start+n-2], fb[start+n-3], fb[start+n-4]} == fcs_of(start, n - 4));
      for (int j = 0; j < m; j++) begin
         e.d   = fb[start + j];
         e.sof = (j == 0);
         e.eof = (j == m - 1);
         e.err = e.eof && ((n > maxl) || anyer || (n < 5));
         e.ok  = e.eof && (n <= maxl) && ok;
         if (which != 0) q1.push_back(e); else q0.push_back(e);
      end
   endfunction

   task automatic drive(input logic [7:0] d, input logic dv, input logic er);
      b0.gmii_rxd_i   = d;
      b0.gmii_rx_dv_i = dv;
      b0.gmii_rx_er_i = er;
      @(posedge clk);
      #1;
   endtask

   task automatic build(input int pre, input bit good);
      logic [31:0] f;
      fb.delete();
      fe.delete();
      for (int i = 0; i < pre; i++) fb.push_back(8'h55);
      fb.push_back(8'hD5);
      foreach (dat[i]) fb.push_back(dat[i]);
      f = fcs_of(pre + 1, dat.size());
      fb.push_back(f[7:0]);
      fb.push_back(f[15:8]);
      fb.push_back(f[23:16]);
      fb.push_back(f[31:24] ^ (good ? 8'h00 : 8'h01));
      foreach (fb[i]) fe.push_back(1'b0);
   endtask

   task automatic xmit(input int gap);
      model(0);
      model(1);
      foreach (fb[i]) drive(fb[i], 1'b1, fe[i]);
      for (int g = 0; g < gap; g++) drive(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
   endtask

   task automatic clean_dat();
      dat.delete();
      for (int i = 0; i < 9; i++) dat.push_back(8'h31 + 8'(i));
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 64; c++) begin
         if (q0.size() == 0 && q1.size() == 0) break;
         @(posedge clk);
         #1;
      end
      chk("drain", 32'(q0.size() + q1.size()), 0);
   endtask

   task automatic mon(input int w, input logic v, input logic s, input logic e,
                      input logic er, input logic ok, input logic [7:0] d);
      exp_t x;
      int   qs;
      if (skip) begin
         if (v && e) eof_seen++;
         return;
      end
      if (!v) begin
         chk($sformatf("markers_without_valid%0d", w), {30'd0, s, e}, 0);
         return;
      end
      qs = (w != 0) ? q1.size() : q0.size();
      chk($sformatf("valid_expected%0d", w), 32'(qs != 0), 1);
      if (qs == 0) return;
      x = (w != 0) ? q1.pop_front() : q0.pop_front();
      chk($sformatf("data%0d", w), 32'(d), 32'(x.d));
      chk($sformatf("sof%0d", w), 32'(s), 32'(x.sof));
      chk($sformatf("eof%0d", w), 32'(e), 32'(x.eof));
      if (x.eof) begin
         chk($sformatf("err%0d", w), 32'(er), 32'(x.err));
         chk($sformatf("crc_ok%0d", w), 32'(ok), 32'(x.ok));
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0, b0.valid_o, b0.sof_o, b0.eof_o, b0.err_o, b0.crc_ok_o, b0.data_o);
         mon(1, b1.valid_o, b1.sof_o, b1.eof_o, b1.err_o, b1.crc_ok_o, b1.data_o);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int pre;
      rst = 1'b1;
      drive(8'h00, 1'b0, 1'b0);
      drive(8'h00, 1'b0, 1'b0);
      drive(8'h00, 1'b0, 1'b0);
      chk("rst_valid", 32'(b0.valid_o), 0);
      chk("rst_sof", 32'(b0.sof_o), 0);
      chk("rst_eof", 32'(b0.eof_o), 0);
      chk("rst_err", 32'(b0.err_o), 0);
      chk("rst_crc_ok", 32'(b0.crc_ok_o), 0);
      chk("rst_data", 32'(b0.data_o), 0);
      rst = 1'b0;
      drive(8'h00, 1'b0, 1'b0);

      // clean "123456789" frame, then the same with a corrupted FCS byte, then rx_er on 0x35
      clean_dat();
      build(7, 1'b1);
      xmit(1);
      build(7, 1'b0);
      xmit(1);
      build(7, 1'b1);
      fe[12] = 1'b1;
      xmit(1);

      // bad preamble 55 55 AA D5 ..., then a clean frame
      build(3, 1'b1);
      fb[2] = 8'hAA;
      xmit(1);
      build(7, 1'b1);
      xmit(1);

      // back-to-back frames separated by a single idle cycle
      build(7, 1'b1);
      xmit(1);
      xmit(1);

      // dv drops right after the SFD
      fb.delete();
      fe.delete();
      fb.push_back(8'h55);
      fb.push_back(8'hD5);
      fe.push_back(1'b0);
      fe.push_back(1'b0);
      xmit(1);

      // minimal frames: FCS only, one byte, one data byte plus FCS
      dat.delete();
      build(1, 1'b1);
      xmit(1);
      fb.delete();
      fe.delete();
      fb.push_back(8'h55);
      fb.push_back(8'hD5);
      fb.push_back(8'hA7);
      repeat (3) fe.push_back(1'b0);
      xmit(1);
      dat.push_back(8'h5A);
      build(2, 1'b1);
      xmit(2);

      // 12 post-SFD bytes: overlong for the MAX_FRAME_LEN=8 instance
      dat.delete();
      for (int i = 0; i < 8; i++) dat.push_back(8'($urandom));
      build(7, 1'b1);
      xmit(2);
      wait_drain();

      // randomized frames
      repeat (40) begin
         dat.delete();
         repeat ($urandom_range(0, 20)) dat.push_back(8'($urandom));
         pre = $urandom_range(1, 7);
         build(pre, $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) fb[$urandom_range(0, pre - 1)] = 8'($urandom);
         for (int i = pre + 1; i < fb.size(); i++) fe[i] = ($urandom_range(0, 15) == 0);
         xmit($urandom_range(1, 3));
      end
      wait_drain();

      // reset in the middle of a payload: nothing further, no eof
      skip     = 1'b1;
      eof_seen = 0;
      clean_dat();
      build(7, 1'b1);
      for (int i = 0; i < 16; i++) drive(fb[i], 1'b1, 1'b0);
      rst = 1'b1;
      drive(fb[16], 1'b1, 1'b0);
      chk("midrst_valid0", 32'(b0.valid_o), 0);
      chk("midrst_eof0", 32'(b0.eof_o), 0);
      chk("midrst_valid1", 32'(b1.valid_o), 0);
      rst = 1'b0;
      for (int i = 17; i < fb.size(); i++) drive(fb[i], 1'b1, 1'b0);
      repeat (4) drive(8'h00, 1'b0, 1'b0);
      skip = 1'b0;
      chk("midrst_no_eof", 32'(eof_seen), 0);

      // frame after the reset decodes normally
      build(7, 1'b1);
      xmit(3);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
